// File: rtl/md_sixbutton_reader.sv
// md_sixbutton_reader: console-side Mega Drive six-button pad poller.
// Walks TH through 8 half-phases, samples synchronized pins and commits a decoded snapshot.
module md_sixbutton_reader #(
  parameter int unsigned PHASE_CYCLES  = 500,
  parameter int unsigned SAMPLE_OFFSET = 400,
  parameter int unsigned GAP_CYCLES    = 100000,
  parameter bit          AUTO_POLL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic poll_req,
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic p4,
  input  logic p6,
  input  logic p9,
  output logic p7,
  output logic up,
  output logic dw,
  output logic lf,
  output logic rg,
  output logic a,
  output logic b,
  output logic c,
  output logic st,
  output logic x,
  output logic y,
  output logic z,
  output logic md,
  output logic present,
  output logic six_btn,
  output logic valid,
  output logic busy
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > PHASE_CYCLES) ? GAP_CYCLES : PHASE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PIN_W   = 6;
  localparam int unsigned BTN_W   = 12;

  // Pin vector layout {p9,p6,p4,p3,p2,p1}
  localparam int unsigned PIN_P1 = 0;
  localparam int unsigned PIN_P2 = 1;
  localparam int unsigned PIN_P3 = 2;
  localparam int unsigned PIN_P4 = 3;
  localparam int unsigned PIN_P6 = 4;
  localparam int unsigned PIN_P9 = 5;

  // Button snapshot layout, active-low
  localparam int unsigned BTN_UP = 0;
  localparam int unsigned BTN_DW = 1;
  localparam int unsigned BTN_LF = 2;
  localparam int unsigned BTN_RG = 3;
  localparam int unsigned BTN_A  = 4;
  localparam int unsigned BTN_B  = 5;
  localparam int unsigned BTN_C  = 6;
  localparam int unsigned BTN_ST = 7;
  localparam int unsigned BTN_Z  = 8;
  localparam int unsigned BTN_Y  = 9;
  localparam int unsigned BTN_X  = 10;
  localparam int unsigned BTN_MD = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POLL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  logic [PIN_W-1:0] pins_raw;
  logic [PIN_W-1:0] sync1_q;
  logic [PIN_W-1:0] sync2_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;

  // Only the phases that carry decoded information are kept
  logic [PIN_W-1:0] ph0_q, ph0_d;
  logic [3:0]       ph1_q, ph1_d;   // {p9,p6,p4,p3}
  logic [3:0]       ph5_q, ph5_d;   // {p4,p3,p2,p1}
  logic [3:0]       ph6_q, ph6_d;   // {p4,p3,p2,p1}

  logic [BTN_W-1:0] btn_q, btn_d;
  logic             present_q, present_d;
  logic             six_q, six_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             p7_q, p7_d;

  assign pins_raw = {p9, p6, p4, p3, p2, p1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= ST_GAP;
      cnt_q     <= '0;
      phase_q   <= '0;
      ph0_q     <= '1;
      ph1_q     <= '1;
      ph5_q     <= '1;
      ph6_q     <= '1;
      btn_q     <= '1;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      p7_q      <= 1'b1;
    end else begin
      sync1_q   <= pins_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      ph0_q     <= ph0_d;
      ph1_q     <= ph1_d;
      ph5_q     <= ph5_d;
      ph6_q     <= ph6_d;
      btn_q     <= btn_d;
      present_q <= present_d;
      six_q     <= six_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      p7_q      <= p7_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    ph0_d     = ph0_q;
    ph1_d     = ph1_q;
    ph5_d     = ph5_q;
    ph6_d     = ph6_q;
    btn_d     = btn_q;
    present_d = present_q;
    six_d     = six_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (poll_req || AUTO_POLL) begin
          state_d = ST_POLL;
          cnt_d   = '0;
          phase_d = '0;
        end
      end

      ST_POLL: begin
        if (cnt_q == CNT_W'(SAMPLE_OFFSET)) begin
          case (phase_q)
            3'd0:    ph0_d = sync2_q;
            3'd1:    ph1_d = sync2_q[PIN_P9:PIN_P3];
            3'd5:    ph5_d = sync2_q[PIN_P4:PIN_P1];
            3'd6:    ph6_d = sync2_q[PIN_P4:PIN_P1];
            default: ;
          endcase
        end
        if (cnt_q == CNT_W'(PHASE_CYCLES - 1)) begin
          cnt_d = '0;
          if (phase_q == 3'd7) begin
            state_d = ST_COMMIT;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // All snapshot fields update together with the valid pulse
      ST_COMMIT: begin
        present_d = (ph1_q[PIN_P3 - PIN_P3] == 1'b0) && (ph1_q[PIN_P4 - PIN_P3] == 1'b0);
        six_d     = present_d && (ph5_q == 4'b0000);
        btn_d     = '1;
        if (present_d) begin
          btn_d[BTN_UP] = ph0_q[PIN_P1];
          btn_d[BTN_DW] = ph0_q[PIN_P2];
          btn_d[BTN_LF] = ph0_q[PIN_P3];
          btn_d[BTN_RG] = ph0_q[PIN_P4];
          btn_d[BTN_B]  = ph0_q[PIN_P6];
          btn_d[BTN_C]  = ph0_q[PIN_P9];
          btn_d[BTN_A]  = ph1_q[PIN_P6 - PIN_P3];
          btn_d[BTN_ST] = ph1_q[PIN_P9 - PIN_P3];
          if (six_d) begin
            btn_d[BTN_Z]  = ph6_q[PIN_P1];
            btn_d[BTN_Y]  = ph6_q[PIN_P2];
            btn_d[BTN_X]  = ph6_q[PIN_P3];
            btn_d[BTN_MD] = ph6_q[PIN_P4];
          end
        end
        valid_d = 1'b1;
        state_d = ST_GAP;
        cnt_d   = '0;
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    endcase

    // TH and busy are registered from the next state so they line up with the phase
    p7_d   = !((state_d == ST_POLL) && phase_d[0]);
    busy_d = (state_d != ST_IDLE);
  end

  assign p7      = p7_q;
  assign up      = btn_q[BTN_UP];
  assign dw      = btn_q[BTN_DW];
  assign lf      = btn_q[BTN_LF];
  assign rg      = btn_q[BTN_RG];
  assign a       = btn_q[BTN_A];
  assign b       = btn_q[BTN_B];
  assign c       = btn_q[BTN_C];
  assign st      = btn_q[BTN_ST];
  assign x       = btn_q[BTN_X];
  assign y       = btn_q[BTN_Y];
  assign z       = btn_q[BTN_Z];
  assign md      = btn_q[BTN_MD];
  assign present = present_q;
  assign six_btn = six_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_md_sixbutton_reader.sv
// tb_md_sixbutton_reader: directed bench for the six-button reader, driven by a
// behavioural pad that counts TH edges and times out after a long TH-high idle.
module tb_md_sixbutton_reader;

  localparam int unsigned PC  = 8;
  localparam int unsigned SO  = 5;
  localparam int unsigned GC  = 16;
  localparam int          LAT = 8 * PC + 1;             // accept edge to valid
  localparam int          PER = 8 * PC + 1 + GC + 1;    // auto-poll period
  localparam int          PAD_TIMEOUT = 12;

  // Button vector {md,x,y,z,st,c,b,a,rg,lf,dw,up}, active-low
  typedef struct {
    string       name;
    logic        pad_on;
    logic        six;
    logic [11:0] btn;
    logic        extra_req;
    logic        exp_present;
    logic        exp_six;
    logic [11:0] exp_btn;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A (requested polls) ----------------
  logic        reset_a;
  logic        poll_a = 1'b0;
  logic        cfg_on_a = 1'b0;
  logic        cfg_six_a = 1'b0;
  logic [11:0] cfg_bt_a = 12'hFFF;
  logic [5:0]  pins_a;
  wire         p7_a, present_a, sixb_a, valid_a, busy_a;
  wire  [11:0] btn_a;
  wire  [13:0] snap_a;

  // ---------------- DUT B (auto poll) ----------------
  logic        reset_b;
  logic        poll_b = 1'b0;
  logic        cfg_bt_b = 1'b0;
  logic [11:0] bt_b = 12'hF7F;
  logic [5:0]  pins_b;
  wire         p7_b, present_b, sixb_b, valid_b, busy_b;
  wire  [11:0] btn_b;

  function automatic logic [5:0] pad_pins(input int k, input logic on, input logic six,
                                          input logic [11:0] bt);
    logic [5:0] r;  // {p9,p6,p4,p3,p2,p1}
    r = 6'h3F;
    if (on) begin
      if (k % 2 == 0) begin
        if (six && k == 6) r = {bt[6], bt[5], bt[11], bt[10], bt[9], bt[8]};
        else               r = {bt[6], bt[5], bt[3], bt[2], bt[1], bt[0]};
      end else begin
        if (six && k == 5)      r = {bt[7], bt[4], 4'b0000};
        else if (six && k == 7) r = {bt[7], bt[4], 4'b1111};
        else                    r = {bt[7], bt[4], 2'b00, bt[1], bt[0]};
      end
    end
    return r;
  endfunction

  // Pad TH-edge counters
  int   k_a = 0, idle_a = 0, k_b = 0, idle_b = 0;
  logic prev_a = 1'b1, prev_b = 1'b1;
  int   vcount_a = 0;

  always @(negedge clk) begin
    if (p7_a != prev_a) begin
      k_a <= k_a + 1; idle_a <= 0;
    end else if (idle_a >= PAD_TIMEOUT) k_a <= 0;
    else idle_a <= idle_a + 1;
    prev_a <= p7_a;
    if (p7_b != prev_b) begin
      k_b <= k_b + 1; idle_b <= 0;
    end else if (idle_b >= PAD_TIMEOUT) k_b <= 0;
    else idle_b <= idle_b + 1;
    prev_b <= p7_b;
    if (valid_a === 1'b1) vcount_a <= vcount_a + 1;
  end

  assign pins_a = pad_pins(k_a, cfg_on_a, cfg_six_a, cfg_bt_a);
  assign pins_b = pad_pins(k_b, 1'b1, 1'b1, bt_b);
  assign snap_a = {present_a, sixb_a, btn_a};

  md_sixbutton_reader #(.PHASE_CYCLES(PC), .SAMPLE_OFFSET(SO), .GAP_CYCLES(GC), .AUTO_POLL(1'b0)) u_dut_a (
    .clk(clk), .reset(reset_a), .poll_req(poll_a),
    .p1(pins_a[0]), .p2(pins_a[1]), .p3(pins_a[2]), .p4(pins_a[3]), .p6(pins_a[4]), .p9(pins_a[5]),
    .p7(p7_a),
    .up(btn_a[0]), .dw(btn_a[1]), .lf(btn_a[2]), .rg(btn_a[3]), .a(btn_a[4]), .b(btn_a[5]),
    .c(btn_a[6]), .st(btn_a[7]), .z(btn_a[8]), .y(btn_a[9]), .x(btn_a[10]), .md(btn_a[11]),
    .present(present_a), .six_btn(sixb_a), .valid(valid_a), .busy(busy_a)
  );

  md_sixbutton_reader #(.PHASE_CYCLES(PC), .SAMPLE_OFFSET(SO), .GAP_CYCLES(GC), .AUTO_POLL(1'b1)) u_dut_b (
    .clk(clk), .reset(reset_b), .poll_req(poll_b),
    .p1(pins_b[0]), .p2(pins_b[1]), .p3(pins_b[2]), .p4(pins_b[3]), .p6(pins_b[4]), .p9(pins_b[5]),
    .p7(p7_b),
    .up(btn_b[0]), .dw(btn_b[1]), .lf(btn_b[2]), .rg(btn_b[3]), .a(btn_b[4]), .b(btn_b[5]),
    .c(btn_b[6]), .st(btn_b[7]), .z(btn_b[8]), .y(btn_b[9]), .x(btn_b[10]), .md(btn_b[11]),
    .present(present_b), .six_btn(sixb_b), .valid(valid_b), .busy(busy_b)
  );

  logic [13:0] prev_snap = {1'b0, 1'b0, 12'hFFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_p7(input int k);
    if (k < 8 * int'(PC)) return ((k / int'(PC)) % 2 == 0);
    return 1'b1;
  endfunction

  task automatic wait_idle_a(input string nm);
    int n;
    n = 0;
    while (busy_a !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_wait"}, 32'(busy_a), 32'd0);
  endtask

  // One accepted poll on DUT A, watched cycle by cycle from the accept edge
  task automatic run_poll(input string nm, input logic extra);
    int vat, vcnt, wave_err, busy_err, hold_err, idle_err;
    vat = -1; vcnt = 0; wave_err = 0; busy_err = 0; hold_err = 0; idle_err = 0;
    wait_idle_a(nm);
    poll_a = 1'b1;
    @(negedge clk);
    poll_a = 1'b0;
    for (int k = 0; k <= LAT + GC; k++) begin
      if (p7_a !== exp_p7(k)) wave_err++;
      if (busy_a !== logic'(k < LAT + GC)) busy_err++;
      if (valid_a === 1'b1) begin
        vcnt++;
        if (vat < 0) vat = k;
      end
      if (k < LAT && snap_a !== prev_snap) hold_err++;
      poll_a = extra && (k == 20 || k == 70);
      @(negedge clk);
    end
    poll_a = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (busy_a !== 1'b0 || valid_a !== 1'b0) idle_err++;
      @(negedge clk);
    end
    chk({nm, "_p7_wave"}, 32'(wave_err), 32'd0);
    chk({nm, "_busy_wave"}, 32'(busy_err), 32'd0);
    chk({nm, "_hold"}, 32'(hold_err), 32'd0);
    chk({nm, "_valid_count"}, 32'(vcnt), 32'd1);
    chk({nm, "_latency"}, 32'(vat), 32'(LAT));
    chk({nm, "_idle_hold"}, 32'(idle_err), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v);
    cfg_on_a  = v.pad_on;
    cfg_six_a = v.six;
    cfg_bt_a  = v.btn;
    run_poll(v.name, v.extra_req);
    chk({v.name, "_present"}, 32'(present_a), 32'(v.exp_present));
    chk({v.name, "_six_btn"}, 32'(sixb_a), 32'(v.exp_six));
    chk({v.name, "_buttons"}, 32'(btn_a), 32'(v.exp_btn));
    prev_snap = {v.exp_present, v.exp_six, v.exp_btn};
  endtask

  vec_t vecs[7];

  initial begin : main_a
    int n, vc0;
    vecs[0] = '{"nopad",        1'b0, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'hFFF};
    vecs[1] = '{"six_a_z",      1'b1, 1'b1, 12'hEEF, 1'b0, 1'b1, 1'b1, 12'hEEF};
    vecs[2] = '{"three_c",      1'b1, 1'b0, 12'hFBF, 1'b0, 1'b1, 1'b0, 12'hFBF};
    vecs[3] = '{"three_up_rg",  1'b1, 1'b0, 12'hBF6, 1'b1, 1'b1, 1'b0, 12'hFF6};
    vecs[4] = '{"six_all",      1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[5] = '{"six_st_xymd",  1'b1, 1'b1, 12'h17F, 1'b0, 1'b1, 1'b1, 12'h17F};
    vecs[6] = '{"nopad_again",  1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0, 12'hFFF};

    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_p7", 32'(p7_a), 32'd1);
    chk("reset_busy", 32'(busy_a), 32'd1);
    chk("reset_valid", 32'(valid_a), 32'd0);
    chk("reset_snapshot", 32'(snap_a), 32'(14'h0FFF));
    reset_a = 1'b0;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Reset asserted mid-poll, in phase 3 (TH low)
    cfg_on_a = 1'b1; cfg_six_a = 1'b0; cfg_bt_a = 12'hFBF;
    wait_idle_a("rst");
    poll_a = 1'b1;
    @(negedge clk);
    poll_a = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_p7_before", 32'(p7_a), 32'd0);
    vc0 = vcount_a;
    reset_a = 1'b1;
    #1;
    chk("rst_p7_async", 32'(p7_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_snapshot", 32'(snap_a), 32'(14'h0FFF));
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_a !== 1'b0 && n < 100);
    chk("rst_gap_len", 32'(n), 32'(GC));
    chk("rst_no_valid", 32'(vcount_a - vc0), 32'd0);
    chk("rst_snapshot_kept", 32'(snap_a), 32'(14'h0FFF));
    prev_snap = 14'h0FFF;
    apply_vec(vecs[1]);

    // Auto-poll instance: st held, then released after the phase-1 sample
    reset_b = 1'b0;
    n = 0;
    while (valid_b !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("auto_first_valid", 32'(valid_b), 32'd1);
    chk("auto_first_present", 32'({present_b, sixb_b}), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("auto_st_held", 32'(btn_b), 32'hF7F);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (valid_b !== 1'b1 && n < 200);
      chk("auto_period", 32'(n), 32'(PER));
    end
    chk("auto_st_last", 32'(btn_b), 32'hF7F);
    repeat (47) @(negedge clk);
    bt_b = 12'hFFF;
    n = 47;
    do begin
      @(negedge clk);
      n++;
    end while (valid_b !== 1'b1 && n < 200);
    chk("auto_period_rel", 32'(n), 32'(PER));
    chk("auto_st_not_yet", 32'(btn_b), 32'hF7F);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid_b !== 1'b1 && n < 200);
    chk("auto_period_next", 32'(n), 32'(PER));
    chk("auto_st_released", 32'(btn_b), 32'hFFF);
    chk("auto_six_kept", 32'({present_b, sixb_b}), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
